l1_istek_hakem: RTL and testbench
=================================

# l1_istek_hakem

Arbiter between the L1 instruction cache controller (l1b) and the L1 data cache controller (l1v), placed in front of the bus controller's single request/response port. It grants one requester at a time with round-robin priority and registers the granted request toward the bus. It tracks the owner of the single outstanding transaction and routes the block-read response back to that owner through a registered response buffer.

## Interface
Parameters:
- ADRES_BIT, 32, request address width
- L1_BLOK_BIT, 128, cache block width (request write data and response read data)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- l1b_istek_adres_i  in  ADRES_BIT  l1b request address
- l1b_istek_veri_i  in  L1_BLOK_BIT  l1b write block
- l1b_istek_yaz_i  in  1  l1b write (1) / read (0)
- l1b_istek_gecerli_i  in  1  l1b request valid
- l1b_istek_hazir_o  out  1  l1b request accepted this cycle when valid
- l1b_veri_o  out  L1_BLOK_BIT  read block to l1b
- l1b_veri_gecerli_o  out  1  l1b response valid
- l1b_veri_hazir_i  in  1  l1b response ready
- l1v_istek_adres_i, l1v_istek_veri_i, l1v_istek_yaz_i, l1v_istek_gecerli_i, l1v_istek_hazir_o  same as l1b set, for l1v
- l1v_istek_onbellekleme_i  in  1  l1v single-word (uncached) access flag
- l1v_veri_o, l1v_veri_gecerli_o, l1v_veri_hazir_i  same as l1b response set, for l1v
- vy_istek_adres_o  out  ADRES_BIT  address to bus controller
- vy_istek_veri_o  out  L1_BLOK_BIT  write block to bus controller
- vy_istek_yaz_o  out  1  write flag to bus controller
- vy_istek_onbellekleme_o  out  1  l1v flag passthrough; always 0 for l1b grants
- vy_istek_gecerli_o  out  1  request valid to bus controller
- vy_istek_hazir_i  in  1  bus controller accepts request
- vy_veri_i  in  L1_BLOK_BIT  read block from bus controller
- vy_veri_gecerli_i  in  1  bus read response valid
- vy_veri_hazir_o  out  1  ready for bus read response

## Operation
- States: BOSTA, ISTEK, YANIT_BEKLE, YANIT. Reset enters BOSTA.
- Priority pointer `son_sahip`. Reset value = l1v, so l1b wins first.
- BOSTA:
  - Grant is combinational from both gecerli inputs and the pointer. A lone valid requester is granted. If both are valid, the requester that is not `son_sahip` is granted.
  - Only the granted requester sees hazir_o=1.
  - On the handshake (gecerli && hazir), latch adres/veri/yaz/onbellekleme into the vy_istek registers, set `sahip`, set `son_sahip`=`sahip`, and go to ISTEK.
- ISTEK:
  - vy_istek_gecerli_o=1 and the payload is held stable.
  - On vy_istek_hazir_i:
    - Write: go to BOSTA. Writes produce no response.
    - Read: go to YANIT_BEKLE.
  - vy_istek_gecerli_o drops in the same edge.
- YANIT_BEKLE:
  - vy_veri_hazir_o=1.
  - On vy_veri_gecerli_i, capture vy_veri_i into the response buffer and go to YANIT.
- YANIT:
  - The owner's veri_gecerli_o=1 and its veri_o = buffer.
  - The other requester's veri_gecerli_o=0 and its veri_o is unchanged.
  - On the owner's veri_hazir_i, go to BOSTA.
- Exactly one transaction is outstanding at a time. Both istek_hazir_o are 0 outside BOSTA.
- vy_veri_gecerli_i outside YANIT_BEKLE is ignored, because vy_veri_hazir_o=0.
- Requesters must hold gecerli and payload until accepted. The arbiter does not re-evaluate the grant against a requester that drops gecerli; the next cycle is re-arbitrated.
- Reset mid-transaction:
  - Abandon the transaction and return to BOSTA with the pointer at its reset value.
  - The bus controller is reset by the same reset, so stale data is never delivered.

## Timing
- Reset values:
  - All gecerli/hazir outputs = 0.
  - vy_istek_adres/veri/yaz/onbellekleme = 0.
  - l1b_veri_o = l1v_veri_o = 0.
  - State = BOSTA; pointer = l1v.
- istek_hazir_o goes high in the first cycle after reset deassertion.
- Request latency: accept at edge T, vy_istek_gecerli_o=1 from T+1.
- Read turnaround: vy data accepted at edge D gives owner veri_gecerli_o=1 from D+1.
- With zero-wait bus handshakes, the minimum read round trip is accept T, bus accept T+1, data T+2, response visible T+3.
- Write: bus accept at edge W gives BOSTA from W+1. The next grant is possible in cycle W+1.
- After a response handshake at edge R, a new grant is possible in cycle R+1.
- No combinational path from any vy_* input to any l1* output.
- The only combinational paths are l1b/l1v_istek_gecerli_i to istek_hazir_o.

## Test plan
- Single l1b read, addr 0x80000040: vy_istek_gecerli_o at T+1 with addr 0x80000040 and yaz=0. vy returns 0xDEADBEEF_..._0001 → l1b_veri_gecerli_o=1 with that block, and l1v_veri_gecerli_o stays 0.
- Simultaneous l1b and l1v reads, held valid for 3 transactions:
  - Grant order is l1b, l1v, l1b.
  - Each response reaches only its owner.
- l1v write with onbellekleme=1, addr 0x20000004: vy_istek_yaz_o=1 and vy_istek_onbellekleme_o=1. No response on either L1 port. BOSTA one cycle after vy_istek_hazir_i.
- Backpressure case:
  - Stimulus: vy_istek_hazir_i low for 5 cycles, then l1v_veri_hazir_i low for 4 cycles.
  - Request payload is stable throughout.
  - Response is held stable.
  - Both istek_hazir_o stay 0.
- Spurious vy_veri_gecerli_i=1 while in ISTEK: ignored, buffer unchanged.
- rst_i asserted while in YANIT_BEKLE:
  - Next cycle all outputs are at reset values.
  - Afterwards a new l1v request is granted before a simultaneous l1b request? No: l1b is granted first, because the pointer was reset.

Source files
------------

// File: rtl/l1_istek_hakem.sv
// Round-robin arbiter between the L1 instruction (l1b) and data (l1v) cache
// controllers in front of the bus controller's single request/response port.
module l1_istek_hakem #(
  parameter int ADRES_BIT   = 32,
  parameter int L1_BLOK_BIT = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic [ADRES_BIT-1:0]   l1b_istek_adres_i,
  input  logic [L1_BLOK_BIT-1:0] l1b_istek_veri_i,
  input  logic                   l1b_istek_yaz_i,
  input  logic                   l1b_istek_gecerli_i,
  output logic                   l1b_istek_hazir_o,
  output logic [L1_BLOK_BIT-1:0] l1b_veri_o,
  output logic                   l1b_veri_gecerli_o,
  input  logic                   l1b_veri_hazir_i,

  input  logic [ADRES_BIT-1:0]   l1v_istek_adres_i,
  input  logic [L1_BLOK_BIT-1:0] l1v_istek_veri_i,
  input  logic                   l1v_istek_yaz_i,
  input  logic                   l1v_istek_gecerli_i,
  input  logic                   l1v_istek_onbellekleme_i,
  output logic                   l1v_istek_hazir_o,
  output logic [L1_BLOK_BIT-1:0] l1v_veri_o,
  output logic                   l1v_veri_gecerli_o,
  input  logic                   l1v_veri_hazir_i,

  output logic [ADRES_BIT-1:0]   vy_istek_adres_o,
  output logic [L1_BLOK_BIT-1:0] vy_istek_veri_o,
  output logic                   vy_istek_yaz_o,
  output logic                   vy_istek_onbellekleme_o,
  output logic                   vy_istek_gecerli_o,
  input  logic                   vy_istek_hazir_i,
  input  logic [L1_BLOK_BIT-1:0] vy_veri_i,
  input  logic                   vy_veri_gecerli_i,
  output logic                   vy_veri_hazir_o
);

  // Handshakes: a transfer happens on a rising edge where gecerli and hazir
  // are both high; the sender holds gecerli and payload stable until then.

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    ISTEK       = 2'd1,
    YANIT_BEKLE = 2'd2,
    YANIT       = 2'd3
  } durum_t;

  localparam logic SAHIP_L1B = 1'b0;
  localparam logic SAHIP_L1V = 1'b1;

  durum_t durum_q, durum_d;
  logic   son_sahip_q;
  logic   sahip_q;

  logic                   secim;
  logic                   secim_gecerli;
  logic                   kabul;

  logic [ADRES_BIT-1:0]   adres_q;
  logic [L1_BLOK_BIT-1:0] veri_q;
  logic                   yaz_q;
  logic                   onbellekleme_q;
  logic [L1_BLOK_BIT-1:0] l1b_veri_q;
  logic [L1_BLOK_BIT-1:0] l1v_veri_q;

  // On a tie the requester that did not own the last grant wins.
  always_comb begin
    secim_gecerli = 1'b0;
    secim         = SAHIP_L1B;
    if (l1b_istek_gecerli_i && l1v_istek_gecerli_i) begin
      secim_gecerli = 1'b1;
      secim         = ~son_sahip_q;
    end else if (l1b_istek_gecerli_i) begin
      secim_gecerli = 1'b1;
      secim         = SAHIP_L1B;
    end else if (l1v_istek_gecerli_i) begin
      secim_gecerli = 1'b1;
      secim         = SAHIP_L1V;
    end
  end

  assign kabul             = (durum_q == BOSTA) && secim_gecerli;
  assign l1b_istek_hazir_o = kabul && (secim == SAHIP_L1B);
  assign l1v_istek_hazir_o = kabul && (secim == SAHIP_L1V);

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:       if (kabul) durum_d = ISTEK;
      ISTEK:       if (vy_istek_hazir_i) durum_d = yaz_q ? BOSTA : YANIT_BEKLE;
      YANIT_BEKLE: if (vy_veri_gecerli_i) durum_d = YANIT;
      YANIT: begin
        if ((sahip_q == SAHIP_L1V) ? l1v_veri_hazir_i : l1b_veri_hazir_i)
          durum_d = BOSTA;
      end
      default:     durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q        <= BOSTA;
      son_sahip_q    <= SAHIP_L1V;
      sahip_q        <= SAHIP_L1B;
      adres_q        <= '0;
      veri_q         <= '0;
      yaz_q          <= 1'b0;
      onbellekleme_q <= 1'b0;
      l1b_veri_q     <= '0;
      l1v_veri_q     <= '0;
    end else begin
      durum_q <= durum_d;
      if (kabul) begin
        sahip_q        <= secim;
        son_sahip_q    <= secim;
        adres_q        <= (secim == SAHIP_L1V) ? l1v_istek_adres_i : l1b_istek_adres_i;
        veri_q         <= (secim == SAHIP_L1V) ? l1v_istek_veri_i : l1b_istek_veri_i;
        yaz_q          <= (secim == SAHIP_L1V) ? l1v_istek_yaz_i : l1b_istek_yaz_i;
        onbellekleme_q <= (secim == SAHIP_L1V) ? l1v_istek_onbellekleme_i : 1'b0;
      end
      // Each port's veri_o doubles as the response buffer, so the
      // non-owner's last block is left untouched.
      if ((durum_q == YANIT_BEKLE) && vy_veri_gecerli_i) begin
        if (sahip_q == SAHIP_L1V) l1v_veri_q <= vy_veri_i;
        else                      l1b_veri_q <= vy_veri_i;
      end
    end
  end

  assign vy_istek_adres_o        = adres_q;
  assign vy_istek_veri_o         = veri_q;
  assign vy_istek_yaz_o          = yaz_q;
  assign vy_istek_onbellekleme_o = onbellekleme_q;
  assign vy_istek_gecerli_o      = (durum_q == ISTEK);
  assign vy_veri_hazir_o         = (durum_q == YANIT_BEKLE);

  assign l1b_veri_o         = l1b_veri_q;
  assign l1v_veri_o         = l1v_veri_q;
  assign l1b_veri_gecerli_o = (durum_q == YANIT) && (sahip_q == SAHIP_L1B);
  assign l1v_veri_gecerli_o = (durum_q == YANIT) && (sahip_q == SAHIP_L1V);

endmodule

// File: tb/tb_l1_istek_hakem.sv
// Bench for l1_istek_hakem: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_l1_istek_hakem;
  localparam int AW = 32;
  localparam int BW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] b_adres, v_adres;
  logic [BW-1:0] b_veri, v_veri;
  logic          b_yaz, v_yaz, v_onb, b_gec, v_gec, b_vh, v_vh;
  logic          b_hazir, v_hazir, b_vg, v_vg;
  logic [BW-1:0] b_vo, v_vo;
  logic [AW-1:0] vy_adres;
  logic [BW-1:0] vy_wveri, vy_veri;
  logic          vy_yaz, vy_onb, vy_gec, vy_hazir, vy_vg, vy_vh;

  l1_istek_hakem #(.ADRES_BIT(AW), .L1_BLOK_BIT(BW)) dut (
    .clk_i(clk), .rst_i(rst),
    .l1b_istek_adres_i(b_adres), .l1b_istek_veri_i(b_veri), .l1b_istek_yaz_i(b_yaz),
    .l1b_istek_gecerli_i(b_gec), .l1b_istek_hazir_o(b_hazir),
    .l1b_veri_o(b_vo), .l1b_veri_gecerli_o(b_vg), .l1b_veri_hazir_i(b_vh),
    .l1v_istek_adres_i(v_adres), .l1v_istek_veri_i(v_veri), .l1v_istek_yaz_i(v_yaz),
    .l1v_istek_gecerli_i(v_gec), .l1v_istek_onbellekleme_i(v_onb), .l1v_istek_hazir_o(v_hazir),
    .l1v_veri_o(v_vo), .l1v_veri_gecerli_o(v_vg), .l1v_veri_hazir_i(v_vh),
    .vy_istek_adres_o(vy_adres), .vy_istek_veri_o(vy_wveri), .vy_istek_yaz_o(vy_yaz),
    .vy_istek_onbellekleme_o(vy_onb), .vy_istek_gecerli_o(vy_gec), .vy_istek_hazir_i(vy_hazir),
    .vy_veri_i(vy_veri), .vy_veri_gecerli_i(vy_vg), .vy_veri_hazir_o(vy_vh)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: one outstanding transaction, described by
  // its owner, payload and which leg (request / data wait / delivery) is open.
  bit            m_ptr, m_pend, m_on_bus, m_wait, m_have, m_owner, m_yaz, m_onb;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wdata, m_buf_b, m_buf_v;
  bit            acc_b, acc_v;
  int            cyc_n = 0;
  int            t_acc = 0;
  int            t_resp = -1;
  logic [0:0]    obs_q[$];
  logic [0:0]    exp_q[$];
  localparam logic [BW-1:0] BLOK_A = 128'hDEADBEEF_00000000_00000000_00000001;

  function automatic logic [BW-1:0] rand_blok();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 1'b1; m_pend = 0; m_on_bus = 0; m_wait = 0; m_have = 0;
    m_owner = 0; m_yaz = 0; m_onb = 0;
    m_addr = '0; m_wdata = '0; m_buf_b = '0; m_buf_v = '0;
  endtask

  function automatic bit exp_grant_b();
    return !m_pend && b_gec && (!v_gec || m_ptr);
  endfunction

  function automatic bit exp_grant_v();
    return !m_pend && v_gec && (!b_gec || !m_ptr);
  endfunction

  task automatic check_outputs();
    check("istek_hazir", 256'({b_hazir, v_hazir}), 256'({exp_grant_b(), exp_grant_v()}));
    check("vy_istek", 256'({vy_gec, vy_yaz, vy_onb, vy_adres, vy_wveri}),
          256'({m_on_bus, m_yaz, m_onb, m_addr, m_wdata}));
    check("vy_veri_hazir", 256'(vy_vh), 256'(m_wait));
    check("l1b_yanit", 256'({b_vg, b_vo}), 256'({m_have && !m_owner, m_buf_b}));
    check("l1v_yanit", 256'({v_vg, v_vo}), 256'({m_have && m_owner, m_buf_v}));
  endtask

  task automatic model_step();
    bit gb, gv;
    gb = exp_grant_b();
    gv = exp_grant_v();
    acc_b = 0;
    acc_v = 0;
    if (rst) begin
      model_reset();
    end else if (!m_pend) begin
      if (gb) begin
        acc_b = 1; m_owner = 0; m_addr = b_adres; m_wdata = b_veri; m_yaz = b_yaz; m_onb = 0;
      end else if (gv) begin
        acc_v = 1; m_owner = 1; m_addr = v_adres; m_wdata = v_veri; m_yaz = v_yaz; m_onb = v_onb;
      end
      if (gb || gv) begin
        m_pend = 1; m_on_bus = 1; m_ptr = m_owner;
      end
    end else if (m_on_bus) begin
      if (vy_hazir) begin
        m_on_bus = 0;
        if (m_yaz) m_pend = 0;
        else       m_wait = 1;
      end
    end else if (m_wait) begin
      if (vy_vg) begin
        m_wait = 0; m_have = 1;
        if (m_owner) m_buf_v = vy_veri;
        else         m_buf_b = vy_veri;
      end
    end else if (m_have) begin
      if (m_owner ? v_vh : b_vh) begin
        m_have = 0; m_pend = 0;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven for the next rising edge.
  task automatic tick();
    #1;
    check_outputs();
    if (b_hazir && b_gec) obs_q.push_back(1'b0);
    if (v_hazir && v_gec) obs_q.push_back(1'b1);
    if (t_resp < 0 && (b_vg || v_vg)) t_resp = cyc_n;
    model_step();
    if (acc_b || acc_v) t_acc = cyc_n;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic wait_accept(input int bound);
    bit got;
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      got = acc_b || acc_v;
    end
    check("accept_seen", 256'(got), 256'(1'b1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b_adres = '0; b_veri = '0; b_yaz = 0; b_gec = 0; b_vh = 1;
    v_adres = '0; v_veri = '0; v_yaz = 0; v_gec = 0; v_onb = 0; v_vh = 1;
    vy_hazir = 0; vy_veri = '0; vy_vg = 0;
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Single l1b read with zero-wait bus.
    b_adres = 32'h80000040; b_veri = rand_blok(); b_yaz = 0; b_gec = 1;
    vy_hazir = 1; vy_vg = 1; vy_veri = BLOK_A;
    t_resp = -1;
    wait_accept(4);
    b_gec = 0;
    repeat (5) tick();
    check("rd_latency", 256'(t_resp - t_acc), 256'(3));
    check("l1b_blok_hold", 256'(b_vo), 256'(BLOK_A));
    check("l1v_untouched", 256'({v_vg, v_vo}), 256'(0));

    // Both requesters held valid for three grants from reset pointer.
    pulse_reset();
    obs_q.delete();
    exp_q = '{1'b0, 1'b1, 1'b0};
    b_adres = $urandom; v_adres = $urandom; v_yaz = 0; v_onb = 0;
    b_gec = 1; v_gec = 1;
    for (int i = 0; i < 60 && obs_q.size() < 3; i++) begin
      vy_veri = rand_blok();
      tick();
      if (acc_b) b_adres = $urandom;
      if (acc_v) v_adres = $urandom;
    end
    b_gec = 0; v_gec = 0;
    repeat (6) begin vy_veri = rand_blok(); tick(); end
    check("grant_count", 256'(obs_q.size()), 256'(3));
    for (int i = 0; i < 3 && i < obs_q.size(); i++)
      check("grant_order", 256'(obs_q[i]), 256'(exp_q[i]));

    // Uncached l1v write: no response, idle again right after bus accept.
    v_adres = 32'h20000004; v_veri = rand_blok(); v_yaz = 1; v_onb = 1; v_gec = 1;
    t_resp = -1;
    wait_accept(4);
    v_gec = 0;
    tick();
    b_adres = 32'h00001000; b_yaz = 1; b_veri = rand_blok(); b_gec = 1;
    wait_accept(1);
    b_gec = 0;
    repeat (3) tick();
    check("wr_no_resp", 256'(t_resp < 0), 256'(1'b1));

    // Backpressure with spurious bus data while the request is pending.
    v_adres = $urandom; v_veri = rand_blok(); v_yaz = 0; v_onb = 0; v_gec = 1;
    vy_hazir = 0;
    wait_accept(4);
    v_gec = 0;
    b_adres = $urandom; b_yaz = 0; b_gec = 1;
    vy_vg = 1;
    repeat (5) begin vy_veri = rand_blok(); tick(); end
    vy_hazir = 1; vy_vg = 0;
    tick();
    vy_vg = 1; vy_veri = rand_blok(); v_vh = 0;
    tick();
    repeat (4) begin vy_veri = rand_blok(); tick(); end
    v_vh = 1;
    wait_accept(4);
    b_gec = 0;
    repeat (5) tick();

    // Reset while waiting for bus data resets the priority pointer too.
    b_adres = $urandom; b_yaz = 0; b_gec = 1; vy_vg = 0;
    wait_accept(4);
    b_gec = 0;
    tick();
    pulse_reset();
    tick();
    obs_q.delete();
    b_gec = 1; v_gec = 1; v_yaz = 0;
    wait_accept(4);
    b_gec = 0; v_gec = 0;
    check("post_rst_first", 256'(obs_q.size() > 0 ? obs_q[0] : 1'bx), 256'(1'b0));
    vy_vg = 1;
    repeat (5) begin vy_veri = rand_blok(); tick(); end

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if (!b_gec && $urandom_range(0, 2) == 0) begin
        b_gec = 1; b_adres = $urandom; b_veri = rand_blok(); b_yaz = 1'($urandom_range(0, 1));
      end
      if (!v_gec && $urandom_range(0, 2) == 0) begin
        v_gec = 1; v_adres = $urandom; v_veri = rand_blok();
        v_yaz = 1'($urandom_range(0, 1)); v_onb = 1'($urandom_range(0, 1));
      end
      vy_hazir = 1'($urandom_range(0, 1));
      vy_vg    = 1'($urandom_range(0, 1));
      vy_veri  = rand_blok();
      b_vh     = 1'($urandom_range(0, 1));
      v_vh     = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 99) == 0);
      tick();
      rst = 1'b0;
      if (acc_b) b_gec = 0;
      if (acc_v) v_gec = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
